// File: rtl/axil_csr_bank.sv
// AXI4-Lite CSR bank: ap_ctrl_hs control with auto-restart, done/ready interrupts,
// host-writable OUT registers and read-only IN status registers.
module axil_csr_bank #(
  parameter int          AddrWidth = 12,
  parameter int          NumOut    = 2,
  parameter int          NumIn     = 1,
  parameter logic [31:0] OutReset  = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AddrWidth-1:0]   araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [31:0]            rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready,
  input  logic [AddrWidth-1:0]   awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  output logic                   ap_start,
  input  logic                   ap_done,
  input  logic                   ap_ready,
  input  logic                   ap_idle,
  output logic                   interrupt,
  output logic [32*NumOut-1:0]   out_regs,
  input  logic [32*NumIn-1:0]    in_regs
);

  localparam int IdxW    = AddrWidth - 2;
  localparam int OutBase = 4;
  localparam int InBase  = OutBase + NumOut;
  localparam logic [IdxW-1:0] IdxCtrl = IdxW'(0);
  localparam logic [IdxW-1:0] IdxGier = IdxW'(1);
  localparam logic [IdxW-1:0] IdxIer  = IdxW'(2);
  localparam logic [IdxW-1:0] IdxIsr  = IdxW'(3);

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate, wstate_n;
  rstate_t rstate, rstate_n;

  logic            aw_held, w_held, wr_commit, wr_hit;
  logic [IdxW-1:0] aw_idx, ar_idx;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic            wr_ctrl, wr_gier, wr_ier, wr_isr;
  logic [NumOut-1:0] wr_out;
  logic            rd_accept, rd_ctrl, rd_err;
  logic [31:0]     rd_data;
  logic            done_bit, ready_bit, auto_restart, gier;
  logic [1:0]      ier, isr, isr_n;
  logic [31:0]     out_q [NumOut];
  logic            unused_addr_lsbs;

  assign unused_addr_lsbs = ^{araddr[1:0], awaddr[1:0]};
  assign ar_idx = araddr[AddrWidth-1:2];

  // Write channel FSM
  always_ff @(posedge clk) begin
    if (reset) wstate <= W_IDLE;
    else       wstate <= wstate_n;
  end

  always_comb begin
    wstate_n = wstate;
    case (wstate)
      W_IDLE: if (aw_held && w_held) wstate_n = W_RESP;
      W_RESP: if (bready) wstate_n = W_IDLE;
    endcase
  end

  always_comb begin
    awready   = (wstate == W_IDLE) && !aw_held;
    wready    = (wstate == W_IDLE) && !w_held;
    bvalid    = (wstate == W_RESP);
    wr_commit = (wstate == W_IDLE) && aw_held && w_held;
  end

  // Each beat is parked until the response handshake retires the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else if (bvalid && bready) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (awvalid && awready) aw_held <= 1'b1;
      if (wvalid && wready)   w_held  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (awvalid && awready) aw_idx <= awaddr[AddrWidth-1:2];
    if (wvalid && wready) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  always_comb begin
    wr_ctrl = wr_commit && (aw_idx == IdxCtrl);
    wr_gier = wr_commit && (aw_idx == IdxGier);
    wr_ier  = wr_commit && (aw_idx == IdxIer);
    wr_isr  = wr_commit && (aw_idx == IdxIsr);
    wr_hit  = (int'(aw_idx) < OutBase);
    wr_out  = '0;
    for (int i = 0; i < NumOut; i++) begin
      if (int'(aw_idx) == OutBase + i) begin
        wr_out[i] = wr_commit;
        wr_hit    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          bresp <= 2'b00;
    else if (wr_commit) bresp <= wr_hit ? 2'b00 : 2'b10;
  end

  // Read channel FSM
  always_ff @(posedge clk) begin
    if (reset) rstate <= R_IDLE;
    else       rstate <= rstate_n;
  end

  always_comb begin
    rstate_n = rstate;
    case (rstate)
      R_IDLE: if (arvalid) rstate_n = R_DATA;
      R_DATA: if (rready) rstate_n = R_IDLE;
    endcase
  end

  always_comb begin
    arready   = (rstate == R_IDLE);
    rvalid    = (rstate == R_DATA);
    rd_accept = (rstate == R_IDLE) && arvalid;
    rd_ctrl   = rd_accept && (ar_idx == IdxCtrl);
  end

  always_comb begin
    rd_data = 32'h0;
    rd_err  = 1'b1;
    case (ar_idx)
      IdxCtrl: begin
        rd_data = {24'h0, auto_restart, 3'b000, ready_bit, ap_idle, done_bit, ap_start};
        rd_err  = 1'b0;
      end
      IdxGier: begin rd_data = {31'h0, gier}; rd_err = 1'b0; end
      IdxIer:  begin rd_data = {30'h0, ier};  rd_err = 1'b0; end
      IdxIsr:  begin rd_data = {30'h0, isr};  rd_err = 1'b0; end
      default: ;
    endcase
    for (int i = 0; i < NumOut; i++) begin
      if (int'(ar_idx) == OutBase + i) begin
        rd_data = out_q[i];
        rd_err  = 1'b0;
      end
    end
    for (int j = 0; j < NumIn; j++) begin
      if (int'(ar_idx) == InBase + j) begin
        rd_data = in_regs[32*j +: 32];
        rd_err  = 1'b0;
      end
    end
  end

  // Snapshot at accept time, so a same-edge write is not visible in this read.
  always_ff @(posedge clk) begin
    if (rd_accept) begin
      rdata <= rd_data;
      rresp <= rd_err ? 2'b10 : 2'b00;
    end
  end

  always_comb begin
    isr_n = isr ^ (wr_isr ? wdata_q[1:0] : 2'b00);
    if (ap_done && ier[0])  isr_n[0] = 1'b1;
    if (ap_ready && ier[1]) isr_n[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ap_start     <= 1'b0;
      done_bit     <= 1'b0;
      ready_bit    <= 1'b0;
      auto_restart <= 1'b0;
      gier         <= 1'b0;
      ier          <= 2'b00;
      isr          <= 2'b00;
      interrupt    <= 1'b0;
      for (int i = 0; i < NumOut; i++) out_q[i] <= OutReset;
    end else begin
      ap_start  <= (ap_start && !(ap_ready && !auto_restart)) || (wr_ctrl && wdata_q[0]);
      done_bit  <= ap_done || (done_bit && !rd_ctrl);
      ready_bit <= ap_ready || (ready_bit && !rd_ctrl);
      if (wr_ctrl) auto_restart <= wdata_q[7];
      if (wr_gier && wstrb_q[0]) gier <= wdata_q[0];
      if (wr_ier && wstrb_q[0])  ier  <= wdata_q[1:0];
      isr       <= isr_n;
      interrupt <= gier && |(isr & ier);
      for (int i = 0; i < NumOut; i++)
        for (int k = 0; k < 4; k++)
          if (wr_out[i] && wstrb_q[k]) out_q[i][8*k +: 8] <= wdata_q[8*k +: 8];
    end
  end

  for (genvar g = 0; g < NumOut; g++) begin : g_out
    assign out_regs[32*g +: 32] = out_q[g];
  end

endmodule

// File: tb/tb_axil_csr_bank.sv
// Directed bench for axil_csr_bank: register table plus control/interrupt/reset sequences.
module tb_axil_csr_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] araddr, awaddr;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic        ap_start, ap_done, ap_ready, ap_idle, interrupt;
  logic [63:0] out_regs;
  logic [31:0] in_regs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_csr_bank #(.AddrWidth(12), .NumOut(2), .NumIn(1), .OutReset(32'h0)) dut (
    .clk(clk), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ap_start(ap_start), .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
    .interrupt(interrupt), .out_regs(out_regs), .in_regs(in_regs)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;   // >0: AW leads W by this many cycles, <0: W leads AW
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
    logic [31:0] exp_out0;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, output logic [1:0] resp);
    int aw_at, w_at, cyc;
    bit aw_done, w_done, aw_f, w_f;
    aw_at = (lead < 0) ? -lead : 0;
    w_at  = (lead > 0) ? lead : 0;
    aw_done = 0; w_done = 0; cyc = 0;
    @(negedge clk);
    while (!(aw_done && w_done) && cyc < 40) begin
      if (cyc == aw_at && !aw_done) begin awaddr = a; awvalid = 1'b1; end
      if (cyc == w_at && !w_done) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(negedge clk);
      cyc++;
      if (aw_f) begin awvalid = 1'b0; aw_done = 1; end
      if (w_f)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    check("wr_accept", 32'(aw_done && w_done), 32'd1);
    bready = 1'b1;
    cyc = 0;
    while (!bvalid && cyc < 20) begin @(negedge clk); cyc++; end
    check("wr_bvalid", 32'(bvalid), 32'd1);
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int cyc;
    cyc = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    arvalid = 1'b0;
    check("rd_latency", 32'(rvalid), 32'd1);
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic pulse(input logic d, input logic r);
    @(negedge clk);
    ap_done = d; ap_ready = r;
    @(negedge clk);
    ap_done = 1'b0; ap_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          cyc;

    vecs[0] = '{12'h010, 32'hDEADBEEF, 4'hF,  2, 2'd0, 32'hDEADBEEF, 2'd0, 32'hDEADBEEF};
    vecs[1] = '{12'h010, 32'h11223344, 4'h5, -1, 2'd0, 32'hDE22BE44, 2'd0, 32'hDE22BE44};
    vecs[2] = '{12'h014, 32'hA5A5A5A5, 4'hC,  0, 2'd0, 32'hA5A50000, 2'd0, 32'hDE22BE44};
    vecs[3] = '{12'h004, 32'hFFFFFFFF, 4'h2,  0, 2'd0, 32'h00000000, 2'd0, 32'hDE22BE44};
    vecs[4] = '{12'h008, 32'h00000003, 4'h1,  0, 2'd0, 32'h00000003, 2'd0, 32'hDE22BE44};
    vecs[5] = '{12'h008, 32'h00000000, 4'hF,  0, 2'd0, 32'h00000000, 2'd0, 32'hDE22BE44};
    vecs[6] = '{12'h018, 32'h12345678, 4'hF,  0, 2'd2, 32'hCAFEF00D, 2'd0, 32'hDE22BE44};
    vecs[7] = '{12'h100, 32'hFFFFFFFF, 4'hF,  0, 2'd2, 32'h00000000, 2'd2, 32'hDE22BE44};
    vecs[8] = '{12'h01C, 32'h00000001, 4'hF,  0, 2'd2, 32'h00000000, 2'd2, 32'hDE22BE44};

    reset = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    ap_done = 1'b0; ap_ready = 1'b0; ap_idle = 1'b0;
    in_regs = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_ap_start", 32'(ap_start), 32'd0);
    check("rst_interrupt", 32'(interrupt), 32'd0);
    check("rst_out0", out_regs[31:0], 32'h0);
    check("rst_out1", out_regs[63:32], 32'h0);

    for (int i = 0; i < NV; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead, resp);
      check($sformatf("v%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_bresp));
      check($sformatf("v%0d_out0", i), out_regs[31:0], vecs[i].exp_out0);
      axi_read(vecs[i].addr, rd, resp);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_rresp));
    end
    check("tbl_out1", out_regs[63:32], 32'hA5A50000);

    // Auto-restart keeps ap_start across ap_ready; status bits clear on read.
    axi_write(12'h000, 32'h00000081, 4'hF, 0, resp);
    check("ctrl_start", 32'(ap_start), 32'd1);
    pulse(1'b1, 1'b1);
    check("auto_restart_hold", 32'(ap_start), 32'd1);
    axi_read(12'h000, rd, resp);
    check("ctrl_read1", rd, 32'h0000008B);
    axi_read(12'h000, rd, resp);
    check("ctrl_read2", rd, 32'h00000081);
    axi_write(12'h000, 32'h00000000, 4'hF, 0, resp);
    check("ctrl_w0_noeffect", 32'(ap_start), 32'd1);
    pulse(1'b0, 1'b1);
    check("ctrl_stop", 32'(ap_start), 32'd0);
    axi_read(12'h000, rd, resp);
    check("ctrl_read3", rd, 32'h00000008);

    // Done interrupt and ISR toggle-on-write.
    axi_write(12'h004, 32'h00000001, 4'hF, 0, resp);
    axi_write(12'h008, 32'h00000001, 4'hF, 0, resp);
    check("irq_idle", 32'(interrupt), 32'd0);
    @(negedge clk); ap_done = 1'b1;
    @(negedge clk); ap_done = 1'b0;
    @(negedge clk);
    check("irq_raised", 32'(interrupt), 32'd1);
    axi_read(12'h00C, rd, resp);
    check("isr_done", rd, 32'h1);
    axi_write(12'h00C, 32'h00000001, 4'hF, 0, resp);
    check("irq_cleared", 32'(interrupt), 32'd0);
    axi_read(12'h00C, rd, resp);
    check("isr_cleared", rd, 32'h0);
    axi_write(12'h00C, 32'h00000002, 4'hF, 0, resp);
    axi_read(12'h00C, rd, resp);
    check("isr_toggle", rd, 32'h2);
    check("irq_masked", 32'(interrupt), 32'd0);

    // Reset while a write response and read data are both pending.
    @(negedge clk);
    awaddr = 12'h010; awvalid = 1'b1; wdata = 32'h00000055; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 12'h010; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    cyc = 0;
    while (!(bvalid && rvalid) && cyc < 10) begin @(negedge clk); cyc++; end
    check("pend_bvalid", 32'(bvalid), 32'd1);
    check("pend_rvalid", 32'(rvalid), 32'd1);
    check("pend_out0", out_regs[31:0], 32'h00000055);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_out0", out_regs[31:0], 32'h0);
    check("mid_rst_awready", 32'(awready), 32'd1);
    check("mid_rst_arready", 32'(arready), 32'd1);
    reset = 1'b0;
    axi_read(12'h00C, rd, resp);
    check("post_rst_isr", rd, 32'h0);
    axi_read(12'h004, rd, resp);
    check("post_rst_gier", rd, 32'h0);
    axi_read(12'h014, rd, resp);
    check("post_rst_out1", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
